regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file, the successor to the single-write/dual-read `regfile` in the datapath. It adds configurable width, depth and read/write port counts, a hardwired-zero register option, optional same-cycle write-to-read bypass, and a synchronous post-reset clear sweep with a `ready` flag. It sits between decode (read addresses) and writeback (write ports) in the core datapath.

## Interface
- `XLEN`, 32: register width in bits.
- `DEPTH`, 32: number of registers, 2..256.
- `NUM_RD`, 2: read ports, 1..4.
- `NUM_WR`, 1: write ports, 1..2.
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and ignores writes.
- `BYPASS`, 0: when 1, a write in the current cycle is forwarded to matching reads in that cycle.
- `ADDR_W`, `$clog2(DEPTH)`: derived, not overridden.
- `clk  in  1`: the only clock; all state changes on its rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `RegWrite  in  NUM_WR`: per-port write enable.
- `rd  in  NUM_WR*ADDR_W`: write addresses, port k at `[k*ADDR_W +: ADDR_W]`.
- `write_data  in  NUM_WR*XLEN`: write data, port k at `[k*XLEN +: XLEN]`.
- `rs  in  NUM_RD*ADDR_W`: read addresses, same packing.
- `read_data  out  NUM_RD*XLEN`: read data, combinational from `rs`.
- `ready  out  1`: array cleared and accepting writes.

## Operation
- FSM states are CLEAR and RUN. Any posedge with `rst`=1 sets state to CLEAR and `clr_cnt` to 1 (or 0 if `ZERO_REG`=0), and sets `ready` to 0.
- CLEAR, `rst`=0: at each posedge, `mem[clr_cnt]` is set to 0 and `clr_cnt` is incremented. The posedge that clears `DEPTH-1` moves the state to RUN.
- `ready` is 1 exactly in RUN.
- In CLEAR, all `RegWrite` are ignored and every `read_data` lane drives 0.
- RUN: at a posedge, each port k with `RegWrite[k]`=1 and a valid `rd` writes `write_data` into `mem[rd]`.
  - An `rd` of `DEPTH` or more is invalid and is ignored.
  - With `ZERO_REG`=1, an `rd` of 0 is ignored.
- Two write ports on the same address in the same cycle: the higher port index wins.
- Read lane j returns `mem[rs_j]`, with these overrides:
  - It returns 0 if `rs_j` is 0 and `ZERO_REG`=1.
  - It returns 0 if `rs_j` is `DEPTH` or more.
  - If `BYPASS`=1, the state is RUN, and a valid write this cycle targets `rs_j`, it returns the write data. Port priority is the same as for writes.
- Width rules: data is `XLEN` wide and is never truncated or extended. Addresses use the low `ADDR_W` bits of each packed field.

## Timing
- Reset values:
  - `ready` = 0.
  - `read_data` = all zero while in CLEAR.
  - All `mem` entries are 0 once RUN is reached.
- Clear latency: `ready` rises after the (`DEPTH-1`)th posedge with `rst` low. With `ZERO_REG`=0 it is the `DEPTH`th posedge. Default build: 31 cycles.
- `rst` reasserted mid-clear or mid-run restarts the sweep from its first index on that posedge. Partial clear progress is not retained.
- Write latency: a value written at posedge N is visible on `read_data` after posedge N with `BYPASS`=0. It is visible in the same cycle as the write with `BYPASS`=1.
- Read latency: 0 cycles, purely combinational. There is no read handshake.

## Structure
- `regfile_defs.vh` holds the shared constants:
  - state encodings `RF_CLEAR` and `RF_RUN`;
  - the default `XLEN` and `DEPTH`;
  - the packing macros for lane slicing.
- The sub-module `regfile_clear_ctrl` owns the FSM, `clr_cnt` and `ready`. It outputs `clr_en` and `clr_addr`.
- The top module holds `mem`, the write-port priority logic and the generate loop over `NUM_RD` read lanes with their bypass muxes.

## Test plan
- Reset sweep: defaults, hold `rst` 2 cycles then release. Then:
  - `ready`=0 for 31 posedges and 1 after;
  - a write to x5=42 during CLEAR is dropped, and x5 reads 0 after `ready`.
- Basic write/read: write x5=42, then read `rs`={5,0}. Response: 42 and 0. Write x0=99, then read x0. Response: 0.
- Dual write collision: `NUM_WR`=2, both ports write x7, with 11 on port 0 and 22 on port 1. Response: x7 reads 22.
- Bypass: `BYPASS`=1, write x9=0xDEADBEEF while `rs`=9 in the same cycle. Response: `read_data`=0xDEADBEEF before the posedge. With `BYPASS`=0 it shows the old value 0 until after the posedge.
- Reset mid-clear and out of range, using `DEPTH`=24 and `NUM_RD`=4:
  - assert `rst` at clear cycle 10; `ready` then takes a full 23 cycles;
  - a write to x30 is ignored, and reads of x30 return 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding,
// default geometry and the address-validity rule used by writes and reads.
package regfile_mp_pkg;

    // CLEAR sweeps the array to zero after reset; RUN is normal operation.
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DEF_XLEN  = 32;
    localparam int RF_DEF_DEPTH = 32;

    // An address names a real, writable register: inside the array and not
    // the hardwired zero register when that option is enabled.
    function automatic logic rf_addr_ok(input int addr, input int depth, input int zero_reg);
        return (addr < depth) && !((zero_reg != 0) && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Datapath-facing bus of the register file. Write and read ports are packed
// lanes: lane k occupies [k*W +: W] of its vector.
//
// Handshake: RegWrite[k] is the per-port valid. A write is accepted on the
// rising edge where RegWrite[k]=1 and ready=1; while ready=0 the write is
// dropped, not held, so the writer must not assume back-pressure. Reads have
// no handshake: read_data follows rs combinationally.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int ADDR_W = 5
);
    logic [NUM_WR-1:0]        RegWrite;
    logic [NUM_WR*ADDR_W-1:0] rd;
    logic [NUM_WR*XLEN-1:0]   write_data;
    logic [NUM_RD*ADDR_W-1:0] rs;
    logic [NUM_RD*XLEN-1:0]   read_data;
    logic                     ready;

    modport master (
        output RegWrite, rd, write_data, rs,
        input  read_data, ready
    );

    modport slave (
        input  RegWrite, rd, write_data, rs,
        output read_data, ready
    );
endinterface

// File: rtl/regfile_mp_clear_ctrl.sv
// Post-reset clear sequencer: walks clr_addr over every clearable register,
// then enters RUN and raises ready.
module regfile_mp_clear_ctrl
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH    = RF_DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output rf_state_t         state
);
    // Register 0 never needs clearing when it is hardwired to zero.
    localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] clr_cnt;

    // Sweep FSM: reset restarts the sweep, the last index hands over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_cnt <= FIRST;
            ready   <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= RF_RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign clr_en   = (state == RF_CLEAR);
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional hardwired
// zero register, optional write-to-read bypass and a post-reset clear sweep.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = RF_DEF_XLEN,
    parameter int DEPTH    = RF_DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus,
    output rf_state_t   dbg_state
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready_q;
    logic              run;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [XLEN-1:0]   wd [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;

    regfile_mp_clear_ctrl #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready_q),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .state    (dbg_state)
    );

    assign bus.ready = ready_q;
    assign run       = (dbg_state == RF_RUN);

    // Unpack write lanes and qualify each port: only in RUN, not under reset,
    // and only to a real writable register.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa[k]    = bus.rd[k*ADDR_W +: ADDR_W];
            wd[k]    = bus.write_data[k*XLEN +: XLEN];
            wr_ok[k] = bus.RegWrite[k] && run && !rst
                       && rf_addr_ok(int'(wa[k]), DEPTH, ZERO_REG);
        end
    end

    // Array update: clear sweep in CLEAR, port writes in RUN. Later ports are
    // applied last so the highest index wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) begin
                mem[clr_addr] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_ok[k]) begin
                        mem[wa[k]] <= wd[k];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [XLEN-1:0]   val;

        assign ra = bus.rs[j*ADDR_W +: ADDR_W];

        // Read lane: zero in CLEAR or for invalid/zero addresses, otherwise the
        // stored word, optionally overridden by this cycle's winning write.
        always_comb begin
            val = '0;
            if (run && rf_addr_ok(int'(ra), DEPTH, ZERO_REG)) begin
                val = mem[ra];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_ok[k] && (wa[k] == ra)) begin
                            val = wd[k];
                        end
                    end
                end
            end
        end

        assign bus.read_data[j*XLEN +: XLEN] = val;
    end

endmodule
